board_writer: RTL and testbench

Move-entry and board-storage block for the tic-tac-toe game. It accepts player moves over a valid/ready handshake, validates them, and writes the mover's 2-bit mark into one of nine board cells. It keeps turn order and the move count, and drives the nine `posN` buses read by the space/win detection logic.

---
 rtl/board_writer.sv | 242 ++++++++++++++++++++++++
 tb/tb_board_writer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_writer.sv
// Move-entry and board-storage block for tic-tac-toe: validates handshaken moves, marks cells, tracks turn/count.
// Optional single-level undo (undo_req port, last-move record) is compiled in with `define BOARD_UNDO_EN.
module board_writer (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       game_lock,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
`ifdef BOARD_UNDO_EN
    input  logic       undo_req,
`endif
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       turn,
    output logic [3:0] move_count,
    output logic       board_full,
    output logic       move_ack,
    output logic       move_err,
    output logic [1:0] err_code
);

    typedef enum logic {
        ST_CHECK = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_RANGE  = 2'b01;
    localparam logic [1:0] ERR_OCC    = 2'b10;
    localparam logic [1:0] ERR_LOCK   = 2'b11;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_req_pos;
    logic [1:0] r_cell [1:9];
    logic       r_turn;
    logic [3:0] r_count;
    logic       r_full;
    logic       r_ack;
    logic       r_err;
    logic [1:0] r_err_code;

    logic       w_in_range;
    logic       w_lock_err;
    logic       w_occupied;
    logic       w_accept;
    logic       w_commit;
    logic       w_reject;
    logic [1:0] w_reject_code;

`ifdef BOARD_UNDO_EN
    logic [3:0] r_last_pos;
    logic       r_last_vld;
    logic       w_undo_sel;
    logic       w_undo_ok;
    logic       w_undo_bad;

    // A move in the same READY cycle takes precedence over an undo.
    assign w_undo_sel = !new_game && (r_state == ST_READY) && undo_req && !move_valid;
    assign w_undo_ok  = w_undo_sel && r_last_vld && !game_lock;
    assign w_undo_bad = w_undo_sel && !(r_last_vld && !game_lock);
`endif

    assign w_in_range = (r_req_pos >= 4'd1) && (r_req_pos <= 4'd9);
    assign w_lock_err = game_lock || (r_count == 4'd9);

    // Compare-based lookup keeps an out-of-range req_pos from indexing past the array.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_occupied = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (r_req_pos == 4'(k) && r_cell[k] != CELL_EMPTY) begin
                w_occupied = 1'b1;
            end
        end
    end

    // FSM process 1: state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (reset) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM process 2: next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (new_game) begin
            w_state_nxt = ST_READY;
        end else begin
            case (r_state)
                ST_READY: if (move_valid) w_state_nxt = ST_CHECK;
                ST_CHECK: w_state_nxt = ST_READY;
                default:  w_state_nxt = ST_READY;
            endcase
        end
    end

    // FSM process 3: outputs and the prioritised CHECK decision.
    always_comb begin
        w_accept      = 1'b0;
        w_commit      = 1'b0;
        w_reject      = 1'b0;
        w_reject_code = ERR_NONE;
        if (!new_game) begin
            case (r_state)
                ST_READY: w_accept = move_valid;
                ST_CHECK: begin
                    if (w_lock_err) begin
                        w_reject      = 1'b1;
                        w_reject_code = ERR_LOCK;
                    end else if (!w_in_range) begin
                        w_reject      = 1'b1;
                        w_reject_code = ERR_RANGE;
                    end else if (w_occupied) begin
                        w_reject      = 1'b1;
                        w_reject_code = ERR_OCC;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign move_ready = (r_state == ST_READY);

    // Board cells.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the cell array is reset explicitly; it is visible state, not scratch memory.
        if (reset) begin
            for (int k = 1; k <= 9; k++) r_cell[k] <= CELL_EMPTY;
        end else if (new_game) begin
            for (int k = 1; k <= 9; k++) r_cell[k] <= CELL_EMPTY;
        end else begin
            for (int k = 1; k <= 9; k++) begin
                if (w_commit && r_req_pos == 4'(k)) begin
                    r_cell[k] <= r_turn ? CELL_P2 : CELL_P1;
                end
`ifdef BOARD_UNDO_EN
                if (w_undo_ok && r_last_pos == 4'(k)) begin
                    r_cell[k] <= CELL_EMPTY;
                end
`endif
            end
        end
    end

    // Turn, count, status and response pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_pos  <= 4'd0;
            r_turn     <= 1'b0;
            r_count    <= 4'd0;
            r_full     <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
`ifdef BOARD_UNDO_EN
            r_last_pos <= 4'd0;
            r_last_vld <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (new_game) begin
                r_turn     <= 1'b0;
                r_count    <= 4'd0;
                r_full     <= 1'b0;
                r_err_code <= ERR_NONE;
`ifdef BOARD_UNDO_EN
                r_last_vld <= 1'b0;
`endif
            end else begin
                if (w_accept) begin
                    r_req_pos <= move_pos;
                end
                if (w_commit) begin
                    r_turn  <= ~r_turn;
                    r_count <= r_count + 4'd1;
                    r_full  <= (r_count == 4'd8);
                    r_ack   <= 1'b1;
`ifdef BOARD_UNDO_EN
                    r_last_pos <= r_req_pos;
                    r_last_vld <= 1'b1;
`endif
                end
                if (w_reject) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_reject_code;
                end
`ifdef BOARD_UNDO_EN
                if (w_undo_ok) begin
                    r_turn     <= ~r_turn;
                    r_count    <= r_count - 4'd1;
                    r_full     <= 1'b0;
                    r_last_vld <= 1'b0;
                    r_ack      <= 1'b1;
                end
                if (w_undo_bad) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_LOCK;
                end
`endif
            end
        end
    end

    assign pos1       = r_cell[1];
    assign pos2       = r_cell[2];
    assign pos3       = r_cell[3];
    assign pos4       = r_cell[4];
    assign pos5       = r_cell[5];
    assign pos6       = r_cell[6];
    assign pos7       = r_cell[7];
    assign pos8       = r_cell[8];
    assign pos9       = r_cell[9];
    assign turn       = r_turn;
    assign move_count = r_count;
    assign board_full = r_full;
    assign move_ack   = r_ack;
    assign move_err   = r_err;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: directed scenarios then random moves against a board-level model.
// Undo scenarios run only when BOARD_UNDO_EN is defined for both bench and design.
module tb_board_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       new_game;
    logic       game_lock;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic       turn;
    logic [3:0] move_count;
    logic       board_full;
    logic       move_ack;
    logic       move_err;
    logic [1:0] err_code;
`ifdef BOARD_UNDO_EN
    logic       undo_req;
    bit         pair_undo = 1'b0;
`endif

    always #5 clk = ~clk;

    board_writer dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .game_lock  (game_lock),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .move_ready (move_ready),
`ifdef BOARD_UNDO_EN
        .undo_req   (undo_req),
`endif
        .pos1       (pos1),
        .pos2       (pos2),
        .pos3       (pos3),
        .pos4       (pos4),
        .pos5       (pos5),
        .pos6       (pos6),
        .pos7       (pos7),
        .pos8       (pos8),
        .pos9       (pos9),
        .turn       (turn),
        .move_count (move_count),
        .board_full (board_full),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .err_code   (err_code)
    );

    logic [1:0] cell_out [1:9];
    assign cell_out[1] = pos1;
    assign cell_out[2] = pos2;
    assign cell_out[3] = pos3;
    assign cell_out[4] = pos4;
    assign cell_out[5] = pos5;
    assign cell_out[6] = pos6;
    assign cell_out[7] = pos7;
    assign cell_out[8] = pos8;
    assign cell_out[9] = pos9;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: only the board contents and the last move; turn/count/full are derived from it.
    int m_cell [1:9];
    bit m_last_vld;
    int m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int k = 1; k <= 9; k++) if (m_cell[k] != 0) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int k = 1; k <= 9; k++) m_cell[k] = 0;
        m_last_vld = 1'b0;
        m_last     = 0;
    endtask

    task automatic check_board(input string tag);
        int c;
        c = m_count();
        for (int k = 1; k <= 9; k++) check($sformatf("%s_pos%0d", tag, k), cell_out[k], m_cell[k]);
        check({tag, "_count"}, move_count, c);
        check({tag, "_turn"}, turn, c % 2);
        check({tag, "_full"}, board_full, (c == 9) ? 1 : 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ack"}, move_ack, 0);
        check({tag, "_err"}, move_err, 0);
    endtask

    // One full move transaction: accept, one CHECK cycle, response, pulse-drop.
    task automatic do_move(input int pos, input bit lock, input string tag);
        int exp_code;
        @(negedge clk);
        check({tag, "_ready_idle"}, move_ready, 1);
        move_valid = 1'b1;
        move_pos   = pos[3:0];
        game_lock  = lock;
`ifdef BOARD_UNDO_EN
        undo_req   = pair_undo;
`endif
        @(negedge clk);
        move_valid = 1'b0;
        move_pos   = 4'($urandom_range(0, 15));
`ifdef BOARD_UNDO_EN
        undo_req   = 1'b0;
`endif
        check({tag, "_ready_check"}, move_ready, 0);
        check_quiet({tag, "_in_check"});
        if (lock || m_count() == 9)      exp_code = 3;
        else if (pos < 1 || pos > 9)     exp_code = 1;
        else if (m_cell[pos] != 0)       exp_code = 2;
        else begin
            exp_code    = 0;
            m_cell[pos] = (m_count() % 2 == 0) ? 1 : 2;
            m_last      = pos;
            m_last_vld  = 1'b1;
        end
        @(negedge clk);
        game_lock = 1'b0;
        check({tag, "_ack"}, move_ack, (exp_code == 0) ? 1 : 0);
        check({tag, "_err"}, move_err, (exp_code != 0) ? 1 : 0);
        if (exp_code != 0) check({tag, "_code"}, err_code, exp_code);
        check({tag, "_ready_back"}, move_ready, 1);
        check_board(tag);
        @(negedge clk);
        check_quiet({tag, "_after"});
    endtask

    task automatic do_new_game(input string tag);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check({tag, "_code"}, err_code, 0);
        check({tag, "_ready"}, move_ready, 1);
        check_quiet(tag);
        check_board(tag);
    endtask

`ifdef BOARD_UNDO_EN
    task automatic do_undo(input bit lock, input string tag);
        bit ok;
        @(negedge clk);
        check({tag, "_ready_idle"}, move_ready, 1);
        undo_req  = 1'b1;
        game_lock = lock;
        @(negedge clk);
        undo_req  = 1'b0;
        game_lock = 1'b0;
        ok = m_last_vld && !lock;
        if (ok) begin
            m_cell[m_last] = 0;
            m_last_vld     = 1'b0;
        end
        check({tag, "_ack"}, move_ack, ok ? 1 : 0);
        check({tag, "_err"}, move_err, ok ? 0 : 1);
        if (!ok) check({tag, "_code"}, err_code, 3);
        check({tag, "_ready"}, move_ready, 1);
        check_board(tag);
        @(negedge clk);
        check_quiet({tag, "_after"});
    endtask
`endif

    initial begin
        reset      = 1'b1;
        new_game   = 1'b0;
        game_lock  = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
`ifdef BOARD_UNDO_EN
        undo_req   = 1'b0;
`endif
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", move_ready, 1);
        check("rst_code", err_code, 0);
        check_quiet("rst");
        check_board("rst");

        // Basic commit, occupied, range and lock rejections.
        do_move(5, 1'b0, "mv5");
        do_move(5, 1'b0, "mv5_again");
        do_move(0, 1'b0, "range0");
        do_move(12, 1'b0, "range12");
        do_move(3, 1'b1, "lock3");

        // Fill the board in order, then one too many.
        do_new_game("ng_fill");
        for (int p = 1; p <= 9; p++) do_move(p, 1'b0, $sformatf("fill%0d", p));
        do_move(1, 1'b0, "tenth");

        // new_game racing a handshake in READY.
        do_new_game("ng_pre");
        do_move(8, 1'b0, "pre_ng");
        @(negedge clk);
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_pos   = 4'd5;
        @(negedge clk);
        new_game   = 1'b0;
        move_valid = 1'b0;
        model_clear();
        check("ng_hs_ready", move_ready, 1);
        check_quiet("ng_hs");
        check_board("ng_hs");
        @(negedge clk);
        check_quiet("ng_hs_after");

        // new_game during CHECK aborts the move silently.
        do_move(2, 1'b0, "pre_ngc");
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'd4;
        @(negedge clk);
        move_valid = 1'b0;
        check("ngc_in_check", move_ready, 0);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check("ngc_ready", move_ready, 1);
        check_quiet("ngc");
        check_board("ngc");
        @(negedge clk);
        check_quiet("ngc_after");

        // Asynchronous reset mid-CHECK.
        do_move(9, 1'b0, "pre_rst");
        do_move(9, 1'b0, "pre_rst_err");
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'd6;
        @(negedge clk);
        move_valid = 1'b0;
        check("arst_in_check", move_ready, 0);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check("arst_ready", move_ready, 1);
        check("arst_code", err_code, 0);
        check_quiet("arst");
        check_board("arst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_quiet("arst_after");
        check_board("arst_after");

`ifdef BOARD_UNDO_EN
        do_move(7, 1'b0, "u_mv7");
        do_undo(1'b0, "undo1");
        do_undo(1'b0, "undo2");
        pair_undo = 1'b1;
        do_move(2, 1'b0, "u_pair");
        pair_undo = 1'b0;
        do_undo(1'b1, "undo_lock");
        do_undo(1'b0, "undo_mv2");
`endif

        // Randomised phase.
        do_new_game("ng_rand");
        for (int i = 0; i < 400; i++) begin
            int r;
            int p;
            r = int'($urandom_range(0, 99));
            if (r < 4 || (m_count() == 9 && r < 40)) begin
                do_new_game($sformatf("r%0d_ng", i));
`ifdef BOARD_UNDO_EN
            end else if (r < 14) begin
                do_undo($urandom_range(0, 7) == 0, $sformatf("r%0d_undo", i));
`endif
            end else begin
                if ($urandom_range(0, 9) < 8) p = int'($urandom_range(1, 9));
                else                          p = int'($urandom_range(0, 15));
`ifdef BOARD_UNDO_EN
                pair_undo = ($urandom_range(0, 9) == 0);
`endif
                do_move(p, $urandom_range(0, 9) == 0, $sformatf("r%0d_mv", i));
`ifdef BOARD_UNDO_EN
                pair_undo = 1'b0;
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
